// File: rtl/oram_pkg.sv
// oram_pkg: shared state encoding, LFSR polynomial and width helpers for the Path-ORAM controller
package oram_pkg;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  typedef enum logic [2:0] {IDLE, LOOKUP, READ, SERVE, EVICT} state_t;
  function automatic int leaf_w(input int d);
    return d - 1;
  endfunction
  function automatic int node_cnt(input int d);
    return (1 << d) - 1;
  endfunction
endpackage

// File: rtl/oram_lfsr.sv
// oram_lfsr: 16-bit Galois LFSR that advances only when step is high, low W bits exposed
module oram_lfsr
  import oram_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] q
);
  logic [15:0] r;
  assign q = r[W-1:0];
  always_ff @(posedge clk) begin
    if (!rst_n) r <= SEED;
    else if (step) r <= (r >> 1) ^ (r[0] ? LFSR_POLY : 16'h0);
  end
endmodule

// File: rtl/oram_path_ctrl.sv
// oram_path_ctrl: Path-ORAM access controller; define ORAM_STATS_EN for live stash_occ reporting
module oram_path_ctrl
  import oram_pkg::*;
#(
  parameter int A = 8,
  parameter int D = 6,
  parameter int K = 3,
  parameter int STASH = 2 * D * K,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [D-1:0]               req_addr,
  input  logic [8*A-1:0]             req_wdata,
  output logic                       resp_valid,
  output logic [8*A-1:0]             resp_rdata,
  output logic                       resp_hit,
  output logic                       err_overflow,
  output logic [$clog2(STASH+1)-1:0] stash_occ
);
  localparam int LW = leaf_w(D);
  localparam int NODES = node_cnt(D);
  localparam int OW = $clog2(STASH + 1);
  typedef struct packed {
    logic           valid;
    logic [D-1:0]   addr;
    logic [LW-1:0]  leaf;
    logic [8*A-1:0] value;
  } tuple_t;
  typedef tuple_t [K-1:0] bucket_t;
  state_t state, state_n;
  logic [3:0] lvl, lvl_n;
  logic [2*LW-1:0] rnd;
  logic accept, wr_q, ovf, hit, done;
  logic [D-1:0] addr_q, node;
  logic [8*A-1:0] wdata_q, rdata;
  logic [LW-1:0] old_leaf, new_leaf, lmask;
  bucket_t tree [NODES];
  bucket_t bk_n;
  tuple_t stash [STASH];
  tuple_t st_n [STASH];
  logic [2**D-1:0] pm_valid;
  logic [LW-1:0] pm_leaf [2**D];
  function automatic logic [D-1:0] path_node(input logic [LW-1:0] leaf, input logic [3:0] l);
    path_node = D'(1);
    for (int i = 0; i < LW; i++) path_node = i < int'(l) ? {path_node[D-2:0], leaf[i]} : path_node;
  endfunction
  assign req_ready = state == IDLE;
  assign accept = req_ready && req_valid;
  assign node = path_node(old_leaf, lvl) - D'(1);
  assign lmask = ~({LW{1'b1}} << lvl);
  oram_lfsr #(.SEED(SEED), .W(2 * LW)) u_lfsr (
    .clk(clk),
    .rst_n(rst_n),
    .step(accept),
    .q(rnd)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lvl <= '0;
    end else begin
      state <= state_n;
      lvl <= lvl_n;
    end
  end
  always_comb begin
    state_n = state;
    lvl_n = lvl;
    case (state)
      IDLE: state_n = accept ? LOOKUP : IDLE;
      LOOKUP: begin
        state_n = READ;
        lvl_n = '0;
      end
      READ: begin
        state_n = lvl == 4'(D - 1) ? SERVE : READ;
        lvl_n = lvl + 4'd1;
      end
      SERVE: begin
        state_n = EVICT;
        lvl_n = 4'(D - 1);
      end
      default: begin
        state_n = lvl == 4'd0 ? IDLE : EVICT;
        lvl_n = lvl - 4'd1;
      end
    endcase
  end
  always_comb begin
    st_n = stash;
    bk_n = tree[node];
    ovf = 1'b0;
    hit = 1'b0;
    done = 1'b0;
    rdata = '0;
    if (state == READ) begin
      for (int k = 0; k < K; k++) begin
        done = !bk_n[k].valid;
        for (int s = 0; s < STASH; s++) begin
          if (!done && !st_n[s].valid) begin
            st_n[s] = bk_n[k];
            bk_n[k].valid = 1'b0;
            done = 1'b1;
          end
        end
        ovf = ovf | !done;
      end
    end
    if (state == SERVE) begin
      for (int s = 0; s < STASH; s++) begin
        if (st_n[s].valid && st_n[s].addr == addr_q) begin
          hit = 1'b1;
          rdata = st_n[s].value;
          st_n[s].value = wr_q ? wdata_q : st_n[s].value;
          st_n[s].leaf = new_leaf;
        end
      end
      done = hit || !wr_q;
      for (int s = 0; s < STASH; s++) begin
        if (!done && !st_n[s].valid) begin
          st_n[s] = '{valid: 1'b1, addr: addr_q, leaf: new_leaf, value: wdata_q};
          done = 1'b1;
        end
      end
      ovf = !done;
    end
    if (state == EVICT) begin
      for (int k = 0; k < K; k++) begin
        done = bk_n[k].valid;
        for (int s = 0; s < STASH; s++) begin
          if (!done && st_n[s].valid && ((st_n[s].leaf ^ old_leaf) & lmask) == '0) begin
            bk_n[k] = st_n[s];
            st_n[s].valid = 1'b0;
            done = 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STASH; s++) stash[s].valid <= 1'b0;
      for (int n = 0; n < NODES; n++)
        for (int k = 0; k < K; k++) tree[n][k].valid <= 1'b0;
      pm_valid <= '0;
      err_overflow <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit <= 1'b0;
    end else begin
      stash <= st_n;
      if (state == READ || state == EVICT) tree[node] <= bk_n;
      if (accept) begin
        wr_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == LOOKUP) begin
        old_leaf <= pm_valid[addr_q] ? pm_leaf[addr_q] : rnd[LW-1:0];
        new_leaf <= rnd[2*LW-1:LW];
        pm_valid[addr_q] <= 1'b1;
        pm_leaf[addr_q] <= rnd[2*LW-1:LW];
      end
      err_overflow <= err_overflow | ovf;
      resp_valid <= state == SERVE;
      if (state == SERVE) begin
        resp_rdata <= rdata;
        resp_hit <= hit;
      end
    end
  end
`ifdef ORAM_STATS_EN
  logic [OW-1:0] occ, peak;
  always_comb begin
    occ = '0;
    for (int s = 0; s < STASH; s++) occ = occ + OW'(st_n[s].valid);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stash_occ <= '0;
      peak <= '0;
    end else begin
      stash_occ <= occ;
      peak <= occ > peak ? occ : peak;
    end
  end
`else
  assign stash_occ = '0;
`endif
endmodule

// File: tb/tb_oram_path_ctrl.sv
// tb_oram_path_ctrl: randomized self-checking bench against a flat associative memory model
module tb_oram_path_ctrl;
  localparam int D = 6;
  localparam int SD = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic req_ready, resp_valid, resp_hit, err_overflow;
  logic [D-1:0] req_addr = '0;
  logic [63:0] req_wdata = '0, resp_rdata;
  logic [5:0] stash_occ;
  logic s_valid = 1'b0, s_write = 1'b0;
  logic s_ready, s_resp_valid, s_hit, s_err;
  logic [SD-1:0] s_addr = '0;
  logic [63:0] s_wdata = '0, s_rdata;
  logic [1:0] s_occ;
  int checks = 0, errors = 0;
  logic [63:0] mem [64];
  bit wrt [64];
  always #5 clk = ~clk;
  oram_path_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .err_overflow(err_overflow), .stash_occ(stash_occ)
  );
  oram_path_ctrl #(.D(SD), .K(1), .STASH(2)) sdut (
    .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_ready(s_ready),
    .req_write(s_write), .req_addr(s_addr), .req_wdata(s_wdata),
    .resp_valid(s_resp_valid), .resp_rdata(s_rdata), .resp_hit(s_hit),
    .err_overflow(s_err), .stash_occ(s_occ)
  );
  function automatic void model_access(input logic w, input logic [5:0] a, input logic [63:0] d,
                                       output logic [63:0] er, output logic eh);
    er = wrt[a] ? mem[a] : 64'd0;
    eh = wrt[a];
    if (w) begin
      mem[a] = d;
      wrt[a] = 1'b1;
    end
  endfunction
  function automatic void model_clear();
    for (int i = 0; i < 64; i++) begin
      wrt[i] = 1'b0;
      mem[i] = '0;
    end
  endfunction
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL ready_timeout got req_ready=%b exp 1", req_ready);
    end
  endtask
  task automatic run_req(input logic w, input logic [5:0] a, input logic [63:0] d,
                         output logic [63:0] rd, output logic h, output int lat);
    wait_ready();
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    h = resp_hit;
  endtask
  task automatic run_small(input logic w, input logic [2:0] a, input logic [63:0] d);
    int n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b1;
    s_write = w;
    s_addr = a;
    s_wdata = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
    n = 1;
    while (!s_resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== SD + 3) begin
      errors++;
      $display("FAIL small_latency got %0d exp %0d", n, SD + 3);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    if (resp_rdata !== 64'd0 || resp_hit !== 1'b0) begin
      errors++; $display("FAIL rst_resp got %h/%b exp 0/0", resp_rdata, resp_hit);
    end
    if (err_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", err_overflow); end
    if (stash_occ !== 6'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", stash_occ); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
  endtask
  task automatic test_timing();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 6'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 2 * D + 3; k++) begin
      checks += 2;
      if (req_ready !== 1'(k == 2 * D + 3)) begin
        errors++; $display("FAIL timing_ready c%0d got %b exp %b", k, req_ready, k == 2 * D + 3);
      end
      if (resp_valid !== 1'(k == D + 3)) begin
        errors++; $display("FAIL timing_resp_valid c%0d got %b exp %b", k, resp_valid, k == D + 3);
      end
      if (k == D + 3) begin
        checks++;
        if (resp_rdata !== 64'd0 || resp_hit !== 1'b0) begin
          errors++; $display("FAIL timing_resp got %h/%b exp 0/0", resp_rdata, resp_hit);
        end
      end
      if (k < 2 * D + 3) begin
        @(posedge clk); #1;
      end
    end
  endtask
  task automatic test_write_read();
    logic [63:0] rd, er;
    logic h, eh;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_req(i == 0, 6'd3, 64'hDEAD_BEEF_0123_4567, rd, h, lat);
      model_access(i == 0, 6'd3, 64'hDEAD_BEEF_0123_4567, er, eh);
      checks += 2;
      if (rd !== er || h !== eh) begin
        errors++; $display("FAIL wr_rd_%0d got %h/%b exp %h/%b", i, rd, h, er, eh);
      end
      if (lat !== D + 3) begin errors++; $display("FAIL wr_rd_latency got %0d exp %0d", lat, D + 3); end
    end
  endtask
  task automatic test_random(input int n);
    logic [63:0] rd, er, d;
    logic h, eh, w;
    logic [5:0] a;
    int lat;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 6'($urandom);
      d = {$urandom, $urandom};
      run_req(w, a, d, rd, h, lat);
      model_access(w, a, d, er, eh);
      checks += 2;
      if (rd !== er || h !== eh) begin
        errors++; $display("FAIL random_%0d addr %0d got %h/%b exp %h/%b", i, a, rd, h, er, eh);
      end
      if (lat !== D + 3) begin errors++; $display("FAIL random_latency got %0d exp %0d", lat, D + 3); end
    end
    checks++;
    if (err_overflow !== 1'b0) begin errors++; $display("FAIL random_overflow got %b exp 0", err_overflow); end
  endtask
  task automatic test_fill();
    logic [63:0] rd, er;
    logic h, eh;
    int lat;
    for (int a = 0; a < 64; a++) begin
      run_req(1'b1, 6'(a), 64'(a) * 64'h0101_0101_0101_0101, rd, h, lat);
      model_access(1'b1, 6'(a), 64'(a) * 64'h0101_0101_0101_0101, er, eh);
      checks++;
      if (rd !== er || h !== eh) begin
        errors++; $display("FAIL fill_wr_%0d got %h/%b exp %h/%b", a, rd, h, er, eh);
      end
    end
    for (int a = 63; a >= 0; a--) begin
      run_req(1'b0, 6'(a), 64'd0, rd, h, lat);
      checks++;
      if (rd !== 64'(a) * 64'h0101_0101_0101_0101 || h !== 1'b1) begin
        errors++; $display("FAIL fill_rd_%0d got %h/%b exp %h/1", a, rd, h, 64'(a) * 64'h0101_0101_0101_0101);
      end
    end
    checks += 2;
    if (err_overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow got %b exp 0", err_overflow); end
    if (stash_occ > 6'd36) begin errors++; $display("FAIL fill_occ got %0d exp <=36", stash_occ); end
  endtask
  task automatic test_back_to_back();
    logic [5:0] a [4];
    logic [63:0] d [4];
    logic [63:0] er [4];
    logic eh [4];
    int acc_cyc [4];
    int n_acc = 0, n_resp = 0;
    logic acc_now;
    logic [5:0] base = 6'($urandom);
    for (int i = 0; i < 4; i++) begin
      a[i] = base + 6'(i * 9);
      d[i] = {$urandom, $urandom};
      model_access(1'b1, a[i], d[i], er[i], eh[i]);
    end
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = a[0];
    req_wdata = d[0];
    for (int c = 0; c < 80; c++) begin
      acc_now = req_valid && req_ready;
      if (resp_valid) begin
        if (n_resp < 4) begin
          checks++;
          if (resp_rdata !== er[n_resp] || resp_hit !== eh[n_resp]) begin
            errors++; $display("FAIL b2b_resp_%0d got %h/%b exp %h/%b", n_resp, resp_rdata, resp_hit, er[n_resp], eh[n_resp]);
          end
        end
        n_resp++;
      end
      @(posedge clk); #1;
      if (acc_now && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc < 4) begin
          req_addr = a[n_acc];
          req_wdata = d[n_acc];
        end else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks += 2;
    if (n_acc !== 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", n_acc); end
    if (n_resp !== 4) begin errors++; $display("FAIL b2b_pulses got %0d exp 4", n_resp); end
    for (int i = 1; i < 4 && i < n_acc; i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 2 * D + 3) begin
        errors++; $display("FAIL b2b_spacing_%0d got %0d exp %0d", i, acc_cyc[i] - acc_cyc[i-1], 2 * D + 3);
      end
    end
  endtask
  task automatic test_reset_mid_evict();
    logic [63:0] rd;
    logic h;
    int lat;
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 6'd7;
    req_wdata = {$urandom, $urandom} | 64'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (D + 4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    checks += 3;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", req_ready); end
    if (resp_valid !== 1'b0 || resp_rdata !== 64'd0) begin
      errors++; $display("FAIL midrst_resp got %b/%h exp 0/0", resp_valid, resp_rdata);
    end
    if (err_overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b exp 0", err_overflow); end
    run_req(1'b0, 6'd7, 64'd0, rd, h, lat);
    checks += 2;
    if (rd !== 64'd0 || h !== 1'b0) begin errors++; $display("FAIL midrst_read got %h/%b exp 0/0", rd, h); end
    if (lat !== D + 3) begin errors++; $display("FAIL midrst_latency got %0d exp %0d", lat, D + 3); end
  endtask
  task automatic test_overflow();
    logic seen = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (s_err !== 1'b0) begin errors++; $display("FAIL ovf_reset got %b exp 0", s_err); end
    for (int a = 0; a < 8; a++) begin
      run_small(1'b1, 3'(a), {$urandom, $urandom});
      checks++;
      if (s_occ > 2'd2) begin errors++; $display("FAIL ovf_occ got %0d exp <=2", s_occ); end
      if (seen) begin
        checks++;
        if (s_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky_w%0d got %b exp 1", a, s_err); end
      end
      seen = seen | s_err;
    end
    for (int i = 0; i < 4; i++) begin
      run_small(1'b0, 3'(i), 64'd0);
      checks++;
      if (s_err !== 1'b1) begin errors++; $display("FAIL ovf_set_r%0d got %b exp 1", i, s_err); end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (s_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", s_err); end
  endtask
  initial begin
    test_reset();
    test_timing();
    test_write_read();
    test_random(120);
    test_fill();
    test_back_to_back();
    test_reset_mid_evict();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
